multicycle_control: RTL and testbench

- Multi-cycle sequencer for the RV64 datapath.
- Replaces single-cycle main_control decoding with a state machine that steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives PC, IR, register-file, ALU and data-memory enables, and waits on a memory-ready handshake.
- Sits between the instruction register and the existing datapath muxes, ALU_CONTROL, reg_file and data_memory.

---
 rtl/multicycle_control.sv | 236 +++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV64 datapath.
// Optional performance counters are enabled by defining MC_PERF_COUNTERS_EN.
module multicycle_control #(
    parameter int width_instruc = 7,
    parameter int MEM_TIMEOUT   = 16,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     run_i,
    input  logic                     halt_i,
    input  logic [width_instruc-1:0] opcode_i,
    input  logic                     zero_i,
    input  logic                     mem_ready_i,
    output logic                     ir_write_o,
    output logic                     pc_write_o,
    output logic                     pc_src_o,
    output logic                     alu_src_o,
    output logic [1:0]               alu_op_o,
    output logic                     mem_read_o,
    output logic                     mem_write_o,
    output logic                     mem_to_reg_o,
    output logic                     reg_write_o,
    output logic                     instr_done_o,
    output logic                     busy_o,
    output logic                     illegal_o,
    output logic                     timeout_o,
    output logic [2:0]               state_o
`ifdef MC_PERF_COUNTERS_EN
    ,
    output logic [CNT_WIDTH-1:0]     cycle_cnt_o,
    output logic [CNT_WIDTH-1:0]     instret_cnt_o,
    output logic [CNT_WIDTH-1:0]     stall_cnt_o
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        C_NONE = 3'd0,
        C_R    = 3'd1,
        C_I    = 3'd2,
        C_LD   = 3'd3,
        C_SD   = 3'd4,
        C_BEQ  = 3'd5
    } cls_t;

    localparam logic [width_instruc-1:0] OP_R   = width_instruc'(7'b0110011);
    localparam logic [width_instruc-1:0] OP_I   = width_instruc'(7'b0010011);
    localparam logic [width_instruc-1:0] OP_LD  = width_instruc'(7'b0000011);
    localparam logic [width_instruc-1:0] OP_SD  = width_instruc'(7'b0100011);
    localparam logic [width_instruc-1:0] OP_BEQ = width_instruc'(7'b1100011);

    // The wait counter only has to reach MEM_TIMEOUT-1; the transition to TRAP
    // happens on the cycle that would have made the count equal MEM_TIMEOUT.
    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        (MEM_TIMEOUT > 0) ? WAIT_W'(MEM_TIMEOUT - 1) : '0;

    state_t            r_state;
    state_t            w_next;
    cls_t              r_cls;
    cls_t              w_dec_cls;
    logic [WAIT_W-1:0] r_wait;
    logic              r_illegal;
    logic              r_timeout;
    logic              w_set_illegal;
    logic              w_set_timeout;

    always_comb begin
        case (opcode_i)
            OP_R:    w_dec_cls = C_R;
            OP_I:    w_dec_cls = C_I;
            OP_LD:   w_dec_cls = C_LD;
            OP_SD:   w_dec_cls = C_SD;
            OP_BEQ:  w_dec_cls = C_BEQ;
            default: w_dec_cls = C_NONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cls     <= C_NONE;
            r_wait    <= '0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_cls <= w_dec_cls;
            end
            if (r_state == S_EXEC) begin
                r_wait <= '0;
            end else if (r_state == S_MEM && !mem_ready_i) begin
                r_wait <= r_wait + 1'b1;
            end
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
            if (w_set_timeout) begin
                r_timeout <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next        = r_state;
        w_set_illegal = 1'b0;
        w_set_timeout = 1'b0;
        ir_write_o    = 1'b0;
        pc_write_o    = 1'b0;
        pc_src_o      = 1'b0;
        alu_src_o     = 1'b0;
        alu_op_o      = 2'b00;
        mem_read_o    = 1'b0;
        mem_write_o   = 1'b0;
        mem_to_reg_o  = 1'b0;
        reg_write_o   = 1'b0;
        instr_done_o  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (halt_i) begin
                    w_next = S_IDLE;
                end else if (run_i) begin
                    w_next = S_FETCH;
                end
            end
            S_FETCH: begin
                ir_write_o = 1'b1;
                w_next     = S_DECODE;
            end
            S_DECODE: begin
                if (w_dec_cls == C_NONE) begin
                    w_next        = S_TRAP;
                    w_set_illegal = 1'b1;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_src_o = (r_cls == C_I) || (r_cls == C_LD) || (r_cls == C_SD);
                case (r_cls)
                    C_BEQ: begin
                        alu_op_o     = 2'b01;
                        pc_write_o   = 1'b1;
                        pc_src_o     = zero_i;
                        instr_done_o = 1'b1;
                        w_next       = halt_i ? S_IDLE : S_FETCH;
                    end
                    C_LD, C_SD: begin
                        alu_op_o = 2'b00;
                        w_next   = S_MEM;
                    end
                    default: begin
                        alu_op_o = 2'b10;
                        w_next   = S_WB;
                    end
                endcase
            end
            S_MEM: begin
                alu_src_o   = 1'b1;
                alu_op_o    = 2'b00;
                mem_read_o  = (r_cls == C_LD);
                mem_write_o = (r_cls == C_SD);
                if (mem_ready_i) begin
                    if (r_cls == C_SD) begin
                        pc_write_o   = 1'b1;
                        instr_done_o = 1'b1;
                        w_next       = halt_i ? S_IDLE : S_FETCH;
                    end else begin
                        w_next = S_WB;
                    end
                end else if (MEM_TIMEOUT != 0 && r_wait == WAIT_LAST) begin
                    w_next        = S_TRAP;
                    w_set_timeout = 1'b1;
                end
            end
            S_WB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = (r_cls == C_LD);
                pc_write_o   = 1'b1;
                instr_done_o = 1'b1;
                w_next       = halt_i ? S_IDLE : S_FETCH;
            end
            S_TRAP: begin
                w_next = S_TRAP;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign busy_o    = (r_state != S_IDLE) && (r_state != S_TRAP);
    assign illegal_o = r_illegal;
    assign timeout_o = r_timeout;
    assign state_o   = r_state;

`ifdef MC_PERF_COUNTERS_EN
    logic [CNT_WIDTH-1:0] r_cycle_cnt;
    logic [CNT_WIDTH-1:0] r_instret_cnt;
    logic [CNT_WIDTH-1:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cycle_cnt   <= '0;
            r_instret_cnt <= '0;
            r_stall_cnt   <= '0;
        end else begin
            if (busy_o) begin
                r_cycle_cnt <= r_cycle_cnt + 1'b1;
            end
            if (instr_done_o) begin
                r_instret_cnt <= r_instret_cnt + 1'b1;
            end
            if (r_state == S_MEM && !mem_ready_i) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign cycle_cnt_o   = r_cycle_cnt;
    assign instret_cnt_o = r_instret_cnt;
    assign stall_cnt_o   = r_stall_cnt;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: an instruction-level model builds
// the expected output vector of every cycle; a negedge process compares it.
module tb_multicycle_control;

    typedef struct packed {
        logic       ir_w;
        logic       pc_w;
        logic       pc_s;
        logic       alu_s;
        logic [1:0] alu_op;
        logic       mrd;
        logic       mwr;
        logic       m2r;
        logic       rw;
        logic       done;
        logic       busy;
        logic       ill;
        logic       tmo;
        logic [2:0] st;
    } outv_t;

    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_LD  = 7'b0000011;
    localparam logic [6:0] OPC_SD  = 7'b0100011;
    localparam logic [6:0] OPC_BEQ = 7'b1100011;
    localparam logic [6:0] OPC_BAD = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       run_i = 1'b0;
    logic       halt_i = 1'b0;
    logic [6:0] opcode_i = 7'd0;
    logic       zero_i = 1'b0;
    logic       mem_ready_i = 1'b0;
    logic       ir_write_o, pc_write_o, pc_src_o, alu_src_o;
    logic [1:0] alu_op_o;
    logic       mem_read_o, mem_write_o, mem_to_reg_o, reg_write_o;
    logic       instr_done_o, busy_o, illegal_o, timeout_o;
    logic [2:0] state_o;
`ifdef MC_PERF_COUNTERS_EN
    logic [31:0] cycle_cnt_o, instret_cnt_o, stall_cnt_o;
`endif

    multicycle_control #(
        .width_instruc(7),
        .MEM_TIMEOUT  (16),
        .CNT_WIDTH    (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run_i       (run_i),
        .halt_i      (halt_i),
        .opcode_i    (opcode_i),
        .zero_i      (zero_i),
        .mem_ready_i (mem_ready_i),
        .ir_write_o  (ir_write_o),
        .pc_write_o  (pc_write_o),
        .pc_src_o    (pc_src_o),
        .alu_src_o   (alu_src_o),
        .alu_op_o    (alu_op_o),
        .mem_read_o  (mem_read_o),
        .mem_write_o (mem_write_o),
        .mem_to_reg_o(mem_to_reg_o),
        .reg_write_o (reg_write_o),
        .instr_done_o(instr_done_o),
        .busy_o      (busy_o),
        .illegal_o   (illegal_o),
        .timeout_o   (timeout_o),
        .state_o     (state_o)
`ifdef MC_PERF_COUNTERS_EN
        ,
        .cycle_cnt_o  (cycle_cnt_o),
        .instret_cnt_o(instret_cnt_o),
        .stall_cnt_o  (stall_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    outv_t w_dut;
    assign w_dut = {ir_write_o, pc_write_o, pc_src_o, alu_src_o, alu_op_o,
                    mem_read_o, mem_write_o, mem_to_reg_o, reg_write_o,
                    instr_done_o, busy_o, illegal_o, timeout_o, state_o};

    int    n_chk = 0;
    int    n_err = 0;
    logic  chk_en = 1'b0;
    outv_t exp_v;
    logic  m_illegal = 1'b0;
    logic  m_timeout = 1'b0;
    int    m_ret = 0;
    int    lat = 0;
    int    last_lat = 0;
    int    mrd_cnt = 0;

    // Per-cycle comparison plus observed latency / memory-request counters.
    always @(negedge clk) begin
        if (chk_en) begin
            n_chk++;
            if (w_dut !== exp_v) begin
                n_err++;
                $display("FAIL cycle_vector t=%0t state=%0d got=%h expected=%h",
                         $time, state_o, w_dut, exp_v);
            end
`ifdef MC_PERF_COUNTERS_EN
            n_chk++;
            if (instret_cnt_o !== 32'(m_ret)) begin
                n_err++;
                $display("FAIL instret_cnt got=%0d expected=%0d", instret_cnt_o, m_ret);
            end
`endif
            if (state_o == 3'd1) lat = 1;
            else if (busy_o) lat++;
            if (instr_done_o) last_lat = lat;
            if (mem_read_o) mrd_cnt++;
        end
    end

    task automatic check_lit(input string name, input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s got=%0d expected=%0d", name, got, want);
        end
    endtask

    function automatic outv_t base(input int st);
        outv_t v;
        v      = '0;
        v.st   = 3'(st);
        v.busy = (st != 0) && (st != 6);
        v.ill  = m_illegal;
        v.tmo  = m_timeout;
        return v;
    endfunction

    task automatic cyc(input outv_t e, input logic run, input logic hlt,
                       input logic z, input logic rdy, input logic rstn);
        run_i       = run;
        halt_i      = hlt;
        zero_i      = z;
        mem_ready_i = rdy;
        rst         = rstn;
        exp_v       = e;
        @(posedge clk);
        #1;
        if (!rstn) begin
            m_ret     = 0;
            m_illegal = 1'b0;
            m_timeout = 1'b0;
        end else if (e.done) begin
            m_ret++;
        end
    endtask

    // Steps one instruction from its FETCH cycle. waits<0: memory never ready.
    // rst_at>=0: reset is driven low on that MEM cycle index.
    task automatic instr(input logic [6:0] op, input logic z, input int waits,
                         input logic hlt, input int rst_at);
        outv_t v;
        logic  is_r, is_i, is_ld, is_sd, is_beq, rdy, rs;
        is_r   = (op == OPC_R);
        is_i   = (op == OPC_I);
        is_ld  = (op == OPC_LD);
        is_sd  = (op == OPC_SD);
        is_beq = (op == OPC_BEQ);
        opcode_i = op;
        v = base(1); v.ir_w = 1'b1;
        cyc(v, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        v = base(2);
        cyc(v, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        if (!(is_r || is_i || is_ld || is_sd || is_beq)) begin
            m_illegal = 1'b1;
            return;
        end
        v = base(3);
        v.alu_s  = is_i || is_ld || is_sd;
        v.alu_op = (is_r || is_i) ? 2'b10 : (is_beq ? 2'b01 : 2'b00);
        if (is_beq) begin
            v.pc_w = 1'b1; v.pc_s = z; v.done = 1'b1;
        end
        cyc(v, 1'b0, hlt, z, 1'b0, 1'b1);
        if (is_beq) return;
        if (is_ld || is_sd) begin
            for (int k = 0; k < 40; k++) begin
                rdy = (waits >= 0) && (k == waits);
                rs  = (k == rst_at) ? 1'b0 : 1'b1;
                v = base(4);
                v.alu_s = 1'b1;
                v.mrd   = is_ld;
                v.mwr   = is_sd;
                if (is_sd && rdy) begin
                    v.pc_w = 1'b1; v.done = 1'b1;
                end
                cyc(v, 1'b0, hlt, 1'b0, rdy, rs);
                if (!rs) return;
                if (rdy) break;
                if (waits < 0 && k == 15) begin
                    m_timeout = 1'b1;
                    return;
                end
            end
            if (is_sd) return;
        end
        v = base(5);
        v.rw = 1'b1; v.m2r = is_ld; v.pc_w = 1'b1; v.done = 1'b1;
        cyc(v, 1'b0, hlt, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held two edges, then idle with run_i low, then a run pulse.
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        cyc(base(0), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(base(0), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(base(0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        instr(OPC_R, 1'b0, 0, 1'b0, -1);
        check_lit("lat_R", last_lat, 4);
        instr(OPC_BEQ, 1'b1, 0, 1'b0, -1);
        check_lit("lat_BEQ", last_lat, 3);
        instr(OPC_BEQ, 1'b0, 0, 1'b0, -1);
        instr(OPC_I, 1'b0, 0, 1'b0, -1);
        instr(OPC_SD, 1'b0, 0, 1'b0, -1);
        check_lit("lat_SD", last_lat, 4);
        instr(OPC_LD, 1'b0, 0, 1'b0, -1);
        check_lit("lat_LD", last_lat, 5);
        mrd_cnt = 0;
        instr(OPC_LD, 1'b0, 3, 1'b0, -1);
        check_lit("lat_LD_wait3", last_lat, 8);
        check_lit("mem_read_cycles", mrd_cnt, 4);

        // Memory never ready: TRAP after 16 MEM cycles; run/halt ignored.
        mrd_cnt = 0;
        instr(OPC_LD, 1'b0, -1, 1'b0, -1);
        check_lit("timeout_mem_cycles", mrd_cnt, 16);
        cyc(base(6), 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(base(6), 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        check_lit("timeout_sticky", int'(timeout_o), 1);
        cyc(base(6), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(base(0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // Illegal opcode traps from DECODE.
        instr(OPC_BAD, 1'b0, 0, 1'b0, -1);
        for (int i = 0; i < 3; i++) cyc(base(6), 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        check_lit("illegal_sticky", int'(illegal_o), 1);
        cyc(base(6), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(base(0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // Halt raised from EXEC of an SD: retire, then IDLE; halt beats run.
        instr(OPC_SD, 1'b0, 1, 1'b1, -1);
        cyc(base(0), 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc(base(0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset during the third MEM cycle of an SD aborts it.
        instr(OPC_SD, 1'b0, -1, 1'b0, 2);
        cyc(base(0), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(base(0), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
